ccip_mmio_initiator: RTL
========================

Name: ccip_mmio_initiator

Overview:
- Host-side MMIO initiator for CCI-P. It is the requester end of the MMIO path, used in testbenches and loopback shims to drive an AFU's CSR space.
- Accepts simple read/write commands on a valid/ready port and converts them into c0 mmioWrValid/mmioRdValid requests toward the AFU.
- Collects c2 mmioRdValid read responses, matches them by TID, and returns them on a response port with timeout detection.
- Sits between a test/control agent and an AFU's cp2af_sRxPort/af2cp_sTxPort.

Parameters:
- TIMEOUT_CYCLES, 512, cycles to wait in RD_WAIT before declaring a read timeout (must be ≥2).
- ERR_CNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at the clock edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_len8  in  1  1 = 8-byte access (hdr.length 2'b01), 0 = 4-byte access (2'b00)
- cmd_addr  in  16  DWORD address, placed in hdr.address
- cmd_data  in  64  write data
- rsp_valid  out  1  read result available; held until rsp_ready
- rsp_ready  in  1  consumer accepts the result
- rsp_data  out  64  read data
- rsp_timeout  out  1  qualifies rsp_valid; 1 = no response arrived
- rsp_tid  out  9  TID of the completed read
- err_cnt  out  ERR_CNT_W  saturating count of stray responses and misaligned commands
- cp2af_sRxPort  out  t_if_ccip_Rx  toward the AFU
- af2cp_sTxPort  in  t_if_ccip_Tx  from the AFU; only c2 is consumed

Behaviour:
- Reset values:
  - cp2af_sRxPort = '0.
  - cmd_ready = 0; it rises the cycle after reset deasserts.
  - rsp_valid, rsp_timeout, rsp_data, rsp_tid = 0.
  - err_cnt = 0; tid counter = 0; state = IDLE.
- States: IDLE, WR, RD_REQ, RD_WAIT, RSP.
- cmd_ready = 1 only in IDLE.
- IDLE:
  - Accepted write goes to WR; accepted read goes to RD_REQ.
  - Misaligned command (cmd_len8 = 1 and cmd_addr[0] = 1): consumed, no bus activity, err_cnt+1, stay in IDLE.
- WR (1 cycle):
  - Drive c0.mmioWrValid = 1 with hdr.address, hdr.length and hdr.tid = tid.
  - c0.data[63:0] = cmd_data for 8B accesses; c0.data[63:0] = {32'b0, cmd_data[31:0]} for 4B; upper data bits 0.
  - tid increments; return to IDLE. No response is produced for writes.
- RD_REQ (1 cycle):
  - Drive c0.mmioRdValid = 1 with the same header rules and data = 0.
  - Latch the outstanding tid, increment tid, clear the timeout counter, go to RD_WAIT.
- Request timing: all c0 outputs are registered. A command accepted at edge N produces a single-cycle request pulse visible in the cycle following edge N. Valid bits are deasserted the next cycle; the header may hold its stale value.
- tid: 9-bit counter, wraps 511 → 0.
- RD_WAIT:
  - On af2cp c2.mmioRdValid with hdr.tid == the latched tid: capture data (4B: upper 32 bits forced to 0), rsp_timeout = 0, go to RSP.
  - rsp_valid asserts the cycle after the response edge, i.e. one cycle of latency.
  - Counter reaches TIMEOUT_CYCLES−1 with no match: rsp_data = 64'hFFFF_FFFF_FFFF_FFFF, rsp_timeout = 1, go to RSP.
  - A match arriving on the same edge as expiry wins; no timeout is reported.
- Stray responses: c2.mmioRdValid with a non-matching tid, or in any state other than RD_WAIT, is ignored and increments err_cnt. This includes late responses after a timeout and responses arriving in RSP.
- err_cnt: saturates at all-ones.
- RSP: rsp_valid held, all rsp_* outputs stable, until rsp_ready; then go to IDLE.
- Single outstanding read only; no pipelining.
- Constant outputs:
  - cp2af_sRxPort.c0.rspValid, c1 fields, c0TxAlmFull and c1TxAlmFull are always 0.
  - af2cp c0/c1 are ignored.
- Reset mid-operation:
  - Returns to IDLE and drops the outstanding read; no rsp is produced.
  - tid resets to 0. A late response after reset counts as stray.

Test Plan:
- Write: cmd write, addr 0x0040, len8 = 0, data 0x1 → one-cycle c0.mmioWrValid, hdr.address 0x0040, length 2'b00, data[63:0] = 0x1; no rsp_valid; cmd_ready back after 2 cycles.
- Read: addr 0x0002, len8 = 1; model AFU returns tid 0 with data 64'ha455_783a_3e90_43b9 after 3 cycles → rsp_valid the next cycle, rsp_data matches, rsp_timeout = 0, rsp_tid = 0.
- Backpressure: rsp_ready held low 5 cycles → rsp_valid and rsp_data stable; cmd_ready = 0 throughout; accepting a new command is possible the cycle after rsp_ready.
- Timeout: TIMEOUT_CYCLES = 16, no c2 response → rsp_timeout = 1 and rsp_data all-ones, 16 cycles after the request. A later response with that tid → err_cnt = 1, no rsp.
- Stray/mismatch: response with tid 5 while waiting on tid 3 → ignored, err_cnt+1. A matching tid 3 response is then still delivered.
- Wrap and misalignment: 512 reads then one more → the final read carries hdr.tid 0. An 8B read at addr 0x0041 → no c0 pulse, err_cnt+1, cmd_ready stays 1.

Source files
------------

// File: rtl/ccip_mmio_initiator.sv
// CCI-P MMIO initiator: turns simple read/write commands into c0 MMIO
// requests toward an AFU and returns TID-matched c2 read responses.

package ccip_if_pkg;
    localparam int unsigned CCIP_CLDATA_W   = 512;
    localparam int unsigned CCIP_MMIOADDR_W = 16;
    localparam int unsigned CCIP_TID_W      = 9;
    localparam int unsigned CCIP_MMIODATA_W = 64;

    typedef struct packed {
        logic [CCIP_MMIOADDR_W-1:0] address;
        logic [1:0]                 length;
        logic                       rsvd;
        logic [CCIP_TID_W-1:0]      tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        logic [CCIP_TID_W-1:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMmioHdr      hdr;
        logic [CCIP_CLDATA_W-1:0] data;
        logic                     rspValid;
        logic                     mmioRdValid;
        logic                     mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic [27:0] hdr;
        logic        rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
    } t_if_ccip_Rx;

    typedef struct packed {
        logic [73:0] hdr;
        logic        valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        logic [79:0]              hdr;
        logic [CCIP_CLDATA_W-1:0] data;
        logic                     valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr        hdr;
        logic                       mmioRdValid;
        logic [CCIP_MMIODATA_W-1:0] data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;
endpackage

module ccip_mmio_initiator
    import ccip_if_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 512,
    parameter int unsigned ERR_CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic                 cmd_len8,
    input  logic [15:0]          cmd_addr,
    input  logic [63:0]          cmd_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [63:0]          rsp_data,
    output logic                 rsp_timeout,
    output logic [8:0]           rsp_tid,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output t_if_ccip_Rx          cp2af_sRxPort,
    input  t_if_ccip_Tx          af2cp_sTxPort
);

    localparam int unsigned TID_W = 9;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR      = 3'd1;
    localparam logic [2:0] S_RD_REQ  = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_RSP     = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [TID_W-1:0]     tid_q, tid_d;
    logic [TID_W-1:0]     out_tid_q, out_tid_d;
    logic                 out_len8_q, out_len8_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_timeout_q, rsp_timeout_d;
    logic [63:0]          rsp_data_q, rsp_data_d;
    logic [TID_W-1:0]     rsp_tid_q, rsp_tid_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    t_if_ccip_Rx          rx_q, rx_d;

    logic                 cmd_fire;
    logic                 misalign;
    logic                 c2_hit;
    logic                 stray;
    logic [1:0]           err_inc;
    logic [ERR_CNT_W:0]   err_sum;
    logic                 unused_tx;

    // Handshake qualification and response classification.
    assign cmd_fire = cmd_valid && cmd_ready_q;
    assign misalign = cmd_fire && cmd_len8 && cmd_addr[0];
    assign c2_hit   = af2cp_sTxPort.c2.mmioRdValid && (state_q == S_RD_WAIT)
                      && (af2cp_sTxPort.c2.hdr.tid == out_tid_q);
    assign stray    = af2cp_sTxPort.c2.mmioRdValid && !c2_hit;
    assign err_inc  = 2'(misalign) + 2'(stray);
    assign err_sum  = {1'b0, err_q} + (ERR_CNT_W + 1)'(err_inc);

    // Request channels from the AFU are never consumed.
    assign unused_tx = ^{af2cp_sTxPort.c0, af2cp_sTxPort.c1};

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        tid_d         = tid_q;
        out_tid_d     = out_tid_q;
        out_len8_d    = out_len8_q;
        tmo_d         = tmo_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_data_d    = rsp_data_q;
        rsp_tid_d     = rsp_tid_q;
        rx_d          = rx_q;
        rx_d.c0.mmioWrValid = 1'b0;
        rx_d.c0.mmioRdValid = 1'b0;
        rx_d.c0.rspValid    = 1'b0;
        rx_d.c1             = '0;
        rx_d.c0TxAlmFull    = 1'b0;
        rx_d.c1TxAlmFull    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_fire && !misalign) begin
                    rx_d.c0.hdr.address = cmd_addr;
                    rx_d.c0.hdr.length  = cmd_len8 ? 2'b01 : 2'b00;
                    rx_d.c0.hdr.rsvd    = 1'b0;
                    rx_d.c0.hdr.tid     = tid_q;
                    rx_d.c0.data        = '0;
                    tid_d               = tid_q + TID_W'(1);
                    if (cmd_write) begin
                        rx_d.c0.mmioWrValid = 1'b1;
                        rx_d.c0.data[63:0]  = cmd_len8 ? cmd_data : {32'h0, cmd_data[31:0]};
                        state_d             = S_WR;
                    end else begin
                        rx_d.c0.mmioRdValid = 1'b1;
                        out_tid_d           = tid_q;
                        out_len8_d          = cmd_len8;
                        tmo_d               = '0;
                        state_d             = S_RD_REQ;
                    end
                end
            end
            S_WR:     state_d = S_IDLE;
            S_RD_REQ: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (c2_hit) begin
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b0;
                    rsp_data_d    = out_len8_q ? af2cp_sTxPort.c2.data
                                               : {32'h0, af2cp_sTxPort.c2.data[31:0]};
                    rsp_tid_d     = out_tid_q;
                    state_d       = S_RSP;
                end else if (tmo_q == TMO_LAST) begin
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_data_d    = 64'hFFFF_FFFF_FFFF_FFFF;
                    rsp_tid_d     = out_tid_q;
                    state_d       = S_RSP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        err_d       = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            tid_q         <= '0;
            out_tid_q     <= '0;
            out_len8_q    <= 1'b0;
            tmo_q         <= '0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_data_q    <= '0;
            rsp_tid_q     <= '0;
            err_q         <= '0;
            rx_q          <= '0;
        end else begin
            state_q       <= state_d;
            tid_q         <= tid_d;
            out_tid_q     <= out_tid_d;
            out_len8_q    <= out_len8_d;
            tmo_q         <= tmo_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_data_q    <= rsp_data_d;
            rsp_tid_q     <= rsp_tid_d;
            err_q         <= err_d;
            rx_q          <= rx_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_tid       = rsp_tid_q;
    assign err_cnt       = err_q;
    assign cp2af_sRxPort = rx_q;

endmodule
